// File: rtl/riscv_core_pkg.sv
// Shared core definitions for the fetch front end: NOP encoding, fetch FSM
// state encoding and the default reset vector.
package riscv_core_pkg;

    // addi x0, x0, 0 -- canonical RISC-V NOP used for IF/ID bubbles
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    // Default PC after reset
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH_REQUEST = 2'd0,
        WAIT_RESPONSE = 2'd1,
        HOLD          = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// One request in flight at a time; exactly one response per accepted request.
interface instruction_fetch_stage_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     instruction_request_valid;
    logic [ADDRESS_WIDTH-1:0] instruction_request_address;
    logic                     instruction_request_ready;
    logic                     instruction_response_valid;
    logic [31:0]              instruction_response_data;

    modport master (
        output instruction_request_valid,
        output instruction_request_address,
        input  instruction_request_ready,
        input  instruction_response_valid,
        input  instruction_response_data
    );

    modport slave (
        input  instruction_request_valid,
        input  instruction_request_address,
        output instruction_request_ready,
        output instruction_response_valid,
        output instruction_response_data
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding register for a fetched word that arrived while
// IF/ID was stalled. Priority: clear > load > drain.
module fetch_skid_buffer
    import riscv_core_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [31:0]              load_data,
    input  logic [ADDRESS_WIDTH-1:0] load_pc,
    input  logic                     drain,
    input  logic                     clear,
    output logic [31:0]              data,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     full
);

    logic [31:0]              data_reg;
    logic [ADDRESS_WIDTH-1:0] pc_reg;
    logic                     full_reg;

    // Capture a word on load; empty on drain or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= NOP_INSTRUCTION;
            pc_reg   <= '0;
            full_reg <= 1'b0;
        end else if (clear) begin
            full_reg <= 1'b0;
        end else if (load) begin
            data_reg <= load_data;
            pc_reg   <= load_pc;
            full_reg <= 1'b1;
        end else if (drain) begin
            full_reg <= 1'b0;
        end
    end

    assign data = data_reg;
    assign pc   = pc_reg;
    assign full = full_reg;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request
// at a time, absorbs variable memory latency and drives the IF/ID register.
// Honours stall_pipeline and redirects on a taken branch from execute.
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds retired-word and
// stall-cycle counters as extra outputs.
module instruction_fetch_stage
    import riscv_core_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_pipeline,
    input  logic                         branch_taken_execute,
    input  logic [ADDRESS_WIDTH-1:0]     branch_target_execute,
    instruction_fetch_stage_if.master    imem,
    output logic [31:0]                  instruction_decode,
    output logic [ADDRESS_WIDTH-1:0]     program_counter_decode,
    output logic                         valid_decode
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                  fetch_count_retired,
    output logic [31:0]                  fetch_stall_cycles
`endif
);

    fetch_state_t             state_reg;
    logic [ADDRESS_WIDTH-1:0] pc_reg;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_reg;
    logic                     discard_reg;
    logic                     request_valid_reg;
    logic [31:0]              instruction_decode_reg;
    logic [ADDRESS_WIDTH-1:0] program_counter_decode_reg;
    logic                     valid_decode_reg;

    logic [31:0]              skid_data;
    logic [ADDRESS_WIDTH-1:0] skid_pc;
    logic                     skid_full;

    logic                     request_fire;
    logic                     response_seen;
    logic                     decode_can_accept;
    logic                     response_to_decode;
    logic                     response_to_skid;
    logic                     skid_to_decode;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus_four;

    // Masking keeps every target bit in the expression; misalignment is simply dropped
    assign redirect_pc  = branch_target_execute & ~ADDRESS_WIDTH'(3);
    assign pc_plus_four = pc_reg + ADDRESS_WIDTH'(4);

    // Handshake and word-routing decisions shared by the FSM, skid and counters
    always_comb begin
        request_fire       = request_valid_reg && imem.instruction_request_ready;
        response_seen      = (state_reg == WAIT_RESPONSE) && imem.instruction_response_valid;
        decode_can_accept  = !stall_pipeline || !valid_decode_reg;
        response_to_decode = !branch_taken_execute && response_seen && !discard_reg && decode_can_accept;
        response_to_skid   = !branch_taken_execute && response_seen && !discard_reg && !decode_can_accept;
        skid_to_decode     = !branch_taken_execute && (state_reg == HOLD) && skid_full && !stall_pipeline;
    end

    fetch_skid_buffer #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (response_to_skid),
        .load_data (imem.instruction_response_data),
        .load_pc   (inflight_pc_reg),
        .drain     (skid_to_decode),
        .clear     (branch_taken_execute),
        .data      (skid_data),
        .pc        (skid_pc),
        .full      (skid_full)
    );

    // Fetch FSM with PC, discard flag, registered request valid and IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg                  <= FETCH_REQUEST;
            pc_reg                     <= RESET_VECTOR;
            inflight_pc_reg            <= '0;
            discard_reg                <= 1'b0;
            request_valid_reg          <= 1'b0;
            instruction_decode_reg     <= NOP_INSTRUCTION;
            program_counter_decode_reg <= '0;
            valid_decode_reg           <= 1'b0;
        end else if (branch_taken_execute) begin
            // Redirect wins over stall: squash IF/ID and refetch from the target
            pc_reg                 <= redirect_pc;
            valid_decode_reg       <= 1'b0;
            instruction_decode_reg <= NOP_INSTRUCTION;
            case (state_reg)
                FETCH_REQUEST: begin
                    if (request_fire) begin
                        discard_reg       <= 1'b1;
                        state_reg         <= WAIT_RESPONSE;
                        request_valid_reg <= 1'b0;
                    end else begin
                        state_reg         <= FETCH_REQUEST;
                        request_valid_reg <= 1'b1;
                    end
                end
                WAIT_RESPONSE: begin
                    if (imem.instruction_response_valid) begin
                        discard_reg       <= 1'b0;
                        state_reg         <= FETCH_REQUEST;
                        request_valid_reg <= 1'b1;
                    end else begin
                        discard_reg       <= 1'b1;
                        state_reg         <= WAIT_RESPONSE;
                        request_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg         <= FETCH_REQUEST;
                    request_valid_reg <= 1'b1;
                end
            endcase
        end else begin
            // Unstalled IF/ID with nothing new becomes a bubble
            if (!stall_pipeline) begin
                valid_decode_reg       <= 1'b0;
                instruction_decode_reg <= NOP_INSTRUCTION;
            end
            case (state_reg)
                FETCH_REQUEST: begin
                    if (request_fire) begin
                        inflight_pc_reg   <= pc_reg;
                        pc_reg            <= pc_plus_four;
                        state_reg         <= WAIT_RESPONSE;
                        request_valid_reg <= 1'b0;
                    end else begin
                        request_valid_reg <= 1'b1;
                    end
                end
                WAIT_RESPONSE: begin
                    if (imem.instruction_response_valid) begin
                        if (discard_reg) begin
                            discard_reg       <= 1'b0;
                            state_reg         <= FETCH_REQUEST;
                            request_valid_reg <= 1'b1;
                        end else if (response_to_decode) begin
                            instruction_decode_reg     <= imem.instruction_response_data;
                            program_counter_decode_reg <= inflight_pc_reg;
                            valid_decode_reg           <= 1'b1;
                            state_reg                  <= FETCH_REQUEST;
                            request_valid_reg          <= 1'b1;
                        end else begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (skid_to_decode) begin
                        instruction_decode_reg     <= skid_data;
                        program_counter_decode_reg <= skid_pc;
                        valid_decode_reg           <= 1'b1;
                        state_reg                  <= FETCH_REQUEST;
                        request_valid_reg          <= 1'b1;
                    end
                end
                default: begin
                    state_reg         <= FETCH_REQUEST;
                    request_valid_reg <= 1'b1;
                end
            endcase
        end
    end

    assign imem.instruction_request_valid   = request_valid_reg;
    assign imem.instruction_request_address = pc_reg;
    assign instruction_decode               = instruction_decode_reg;
    assign program_counter_decode           = program_counter_decode_reg;
    assign valid_decode                     = valid_decode_reg;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_count_retired_reg;
    logic [31:0] fetch_stall_cycles_reg;

    // Count words delivered to decode and cycles spent waiting on memory or decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_retired_reg <= '0;
            fetch_stall_cycles_reg  <= '0;
        end else begin
            if (response_to_decode || skid_to_decode) begin
                fetch_count_retired_reg <= fetch_count_retired_reg + 32'd1;
            end
            if ((state_reg == WAIT_RESPONSE) || (state_reg == HOLD)) begin
                fetch_stall_cycles_reg <= fetch_stall_cycles_reg + 32'd1;
            end
        end
    end

    assign fetch_count_retired = fetch_count_retired_reg;
    assign fetch_stall_cycles  = fetch_stall_cycles_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage. The memory side
// is driven by hand from each scenario task; fetched words are a fixed
// function of their address so expected IF/ID contents are known up front.
module tb_instruction_fetch_stage;
    import riscv_core_pkg::*;

    localparam int AW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_pipeline;
    logic          branch_taken_execute;
    logic [AW-1:0] branch_target_execute;
    logic [31:0]   instruction_decode;
    logic [AW-1:0] program_counter_decode;
    logic          valid_decode;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]   fetch_count_retired;
    logic [31:0]   fetch_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    instruction_fetch_stage_if #(.ADDRESS_WIDTH(AW)) imem_bus ();

    always #5 clk = ~clk;

    instruction_fetch_stage #(
        .ADDRESS_WIDTH (AW),
        .RESET_VECTOR  (32'h0000_0000)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .stall_pipeline         (stall_pipeline),
        .branch_taken_execute   (branch_taken_execute),
        .branch_target_execute  (branch_target_execute),
        .imem                   (imem_bus.master),
        .instruction_decode     (instruction_decode),
        .program_counter_decode (program_counter_decode),
        .valid_decode           (valid_decode)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetch_count_retired    (fetch_count_retired),
        .fetch_stall_cycles     (fetch_stall_cycles)
`endif
    );

    function automatic logic [31:0] word_for(input logic [AW-1:0] addr);
        return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
    endfunction

    // Advance one clock; outputs are then stable 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_pipeline = 1'b0;
        branch_taken_execute = 1'b0;
        branch_target_execute = '0;
        imem_bus.instruction_request_ready = 1'b0;
        imem_bus.instruction_response_valid = 1'b0;
        imem_bus.instruction_response_data = '0;
        step();
        step();
        checks++; if (imem_bus.instruction_request_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_bus.instruction_request_valid); end
        checks++; if (valid_decode !== 1'b0) begin errors++; $display("FAIL reset_valid_decode got=%b exp=0", valid_decode); end
        checks++; if (instruction_decode !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instruction_decode, NOP); end
        checks++; if (program_counter_decode !== 32'h0) begin errors++; $display("FAIL reset_pc_decode got=%h exp=0", program_counter_decode); end
        rst_n = 1'b1;
        imem_bus.instruction_request_ready = 1'b1;
        step();
        checks++; if (imem_bus.instruction_request_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got=%b exp=1", imem_bus.instruction_request_valid); end
        $display("test_reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            logic [AW-1:0] a;
            a = AW'(i * 4);
            checks++; if (imem_bus.instruction_request_valid !== 1'b1 || imem_bus.instruction_request_address !== a) begin
                errors++; $display("FAIL zw_req got=%b/%h exp=1/%h", imem_bus.instruction_request_valid, imem_bus.instruction_request_address, a);
            end
            step();
            imem_bus.instruction_response_valid = 1'b1;
            imem_bus.instruction_response_data = word_for(a);
            checks++; if (imem_bus.instruction_request_valid !== 1'b0 || valid_decode !== 1'b0) begin
                errors++; $display("FAIL zw_wait got=req%b/vd%b exp=0/0", imem_bus.instruction_request_valid, valid_decode);
            end
            step();
            imem_bus.instruction_response_valid = 1'b0;
            checks++; if (valid_decode !== 1'b1 || program_counter_decode !== a || instruction_decode !== word_for(a)) begin
                errors++; $display("FAIL zw_ifid got=%b/%h/%h exp=1/%h/%h", valid_decode, program_counter_decode, instruction_decode, a, word_for(a));
            end
        end
        $display("test_zero_wait: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_stall_skid();
        step();                                   // accept 0xC
        imem_bus.instruction_response_valid = 1'b1;
        imem_bus.instruction_response_data = word_for(32'hC);
        step();                                   // 0xC into IF/ID
        imem_bus.instruction_response_valid = 1'b0;
        stall_pipeline = 1'b1;
        step();                                   // accept 0x10 while stalled
        checks++; if (valid_decode !== 1'b1 || program_counter_decode !== 32'hC) begin
            errors++; $display("FAIL skid_pre got=%b/%h exp=1/0000000c", valid_decode, program_counter_decode);
        end
        imem_bus.instruction_response_valid = 1'b1;
        imem_bus.instruction_response_data = word_for(32'h10);
        step();                                   // 0x10 goes to skid
        imem_bus.instruction_response_valid = 1'b0;
        checks++; if (valid_decode !== 1'b1 || program_counter_decode !== 32'hC || instruction_decode !== word_for(32'hC)) begin
            errors++; $display("FAIL skid_hold_ifid got=%b/%h/%h exp=1/0000000c/%h", valid_decode, program_counter_decode, instruction_decode, word_for(32'hC));
        end
        checks++; if (imem_bus.instruction_request_valid !== 1'b0) begin errors++; $display("FAIL skid_hold_req got=%b exp=0", imem_bus.instruction_request_valid); end
        step();
        checks++; if (imem_bus.instruction_request_valid !== 1'b0 || program_counter_decode !== 32'hC) begin
            errors++; $display("FAIL skid_hold2 got=req%b/pc%h exp=0/0000000c", imem_bus.instruction_request_valid, program_counter_decode);
        end
        stall_pipeline = 1'b0;
        step();                                   // skid drains into IF/ID
        checks++; if (valid_decode !== 1'b1 || program_counter_decode !== 32'h10 || instruction_decode !== word_for(32'h10)) begin
            errors++; $display("FAIL skid_drain got=%b/%h/%h exp=1/00000010/%h", valid_decode, program_counter_decode, instruction_decode, word_for(32'h10));
        end
        checks++; if (imem_bus.instruction_request_valid !== 1'b1 || imem_bus.instruction_request_address !== 32'h14) begin
            errors++; $display("FAIL skid_next_req got=%b/%h exp=1/00000014", imem_bus.instruction_request_valid, imem_bus.instruction_request_address);
        end
        $display("test_stall_skid: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_branch_discard();
        for (int i = 0; i < 3; i++) begin         // fetch 0x14, 0x18, 0x1C
            step();
            imem_bus.instruction_response_valid = 1'b1;
            imem_bus.instruction_response_data = word_for(AW'(32'h14 + i * 4));
            step();
            imem_bus.instruction_response_valid = 1'b0;
        end
        step();                                   // accept 0x20
        branch_taken_execute = 1'b1;
        branch_target_execute = 32'h200;
        step();                                   // redirect while waiting
        branch_taken_execute = 1'b0;
        checks++; if (imem_bus.instruction_request_valid !== 1'b0 || valid_decode !== 1'b0) begin
            errors++; $display("FAIL br_wait got=req%b/vd%b exp=0/0", imem_bus.instruction_request_valid, valid_decode);
        end
        imem_bus.instruction_response_valid = 1'b1;
        imem_bus.instruction_response_data = word_for(32'h20);
        step();                                   // stale 0x20 word dropped
        imem_bus.instruction_response_valid = 1'b0;
        checks++; if (valid_decode !== 1'b0) begin errors++; $display("FAIL br_discard_valid got=%b exp=0", valid_decode); end
        checks++; if (imem_bus.instruction_request_valid !== 1'b1 || imem_bus.instruction_request_address !== 32'h200) begin
            errors++; $display("FAIL br_target_req got=%b/%h exp=1/00000200", imem_bus.instruction_request_valid, imem_bus.instruction_request_address);
        end
        $display("test_branch_discard: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_branch_same_cycle();
        step();                                   // accept 0x200
        imem_bus.instruction_response_valid = 1'b1;
        imem_bus.instruction_response_data = word_for(32'h200);
        branch_taken_execute = 1'b1;
        branch_target_execute = 32'h300;
        step();
        imem_bus.instruction_response_valid = 1'b0;
        branch_taken_execute = 1'b0;
        checks++; if (valid_decode !== 1'b0) begin errors++; $display("FAIL same_valid got=%b exp=0", valid_decode); end
        checks++; if (imem_bus.instruction_request_valid !== 1'b1 || imem_bus.instruction_request_address !== 32'h300) begin
            errors++; $display("FAIL same_req got=%b/%h exp=1/00000300", imem_bus.instruction_request_valid, imem_bus.instruction_request_address);
        end
        step();                                   // accept 0x300
        imem_bus.instruction_response_valid = 1'b1;
        imem_bus.instruction_response_data = word_for(32'h300);
        step();                                   // must not be discarded
        imem_bus.instruction_response_valid = 1'b0;
        checks++; if (valid_decode !== 1'b1 || program_counter_decode !== 32'h300 || instruction_decode !== word_for(32'h300)) begin
            errors++; $display("FAIL same_no_discard got=%b/%h/%h exp=1/00000300/%h", valid_decode, program_counter_decode, instruction_decode, word_for(32'h300));
        end
        $display("test_branch_same_cycle: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_misaligned_stall();
        imem_bus.instruction_request_ready = 1'b0;
        stall_pipeline = 1'b1;
        branch_taken_execute = 1'b1;
        branch_target_execute = 32'h103;
        step();
        branch_taken_execute = 1'b0;
        checks++; if (valid_decode !== 1'b0 || instruction_decode !== NOP) begin
            errors++; $display("FAIL mis_squash got=%b/%h exp=0/%h", valid_decode, instruction_decode, NOP);
        end
        checks++; if (imem_bus.instruction_request_valid !== 1'b1 || imem_bus.instruction_request_address !== 32'h100) begin
            errors++; $display("FAIL mis_req got=%b/%h exp=1/00000100", imem_bus.instruction_request_valid, imem_bus.instruction_request_address);
        end
        $display("test_misaligned_stall: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_midflight();
        imem_bus.instruction_request_ready = 1'b1;
        step();                                   // accept 0x100 (still stalled)
        imem_bus.instruction_response_valid = 1'b1;
        imem_bus.instruction_response_data = word_for(32'h100);
        step();                                   // empty IF/ID accepts despite stall
        imem_bus.instruction_response_valid = 1'b0;
        checks++; if (valid_decode !== 1'b1 || program_counter_decode !== 32'h100) begin
            errors++; $display("FAIL empty_accept got=%b/%h exp=1/00000100", valid_decode, program_counter_decode);
        end
        step();                                   // accept 0x104, now waiting
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (valid_decode !== 1'b0 || instruction_decode !== NOP || program_counter_decode !== 32'h0) begin
            errors++; $display("FAIL async_reset_ifid got=%b/%h/%h exp=0/%h/00000000", valid_decode, instruction_decode, program_counter_decode, NOP);
        end
        checks++; if (imem_bus.instruction_request_valid !== 1'b0) begin errors++; $display("FAIL async_reset_req got=%b exp=0", imem_bus.instruction_request_valid); end
        step();
        step();
        rst_n = 1'b1;
        stall_pipeline = 1'b0;
        step();
        checks++; if (imem_bus.instruction_request_valid !== 1'b1 || imem_bus.instruction_request_address !== 32'h0) begin
            errors++; $display("FAIL post_reset_req got=%b/%h exp=1/00000000", imem_bus.instruction_request_valid, imem_bus.instruction_request_address);
        end
        step();                                   // accept 0x0
        imem_bus.instruction_response_valid = 1'b1;
        imem_bus.instruction_response_data = word_for(32'h0);
        step();
        imem_bus.instruction_response_valid = 1'b0;
        checks++; if (valid_decode !== 1'b1 || program_counter_decode !== 32'h0 || instruction_decode !== word_for(32'h0)) begin
            errors++; $display("FAIL post_reset_ifid got=%b/%h/%h exp=1/00000000/%h", valid_decode, program_counter_decode, instruction_decode, word_for(32'h0));
        end
`ifdef FETCH_PERF_COUNTERS_EN
        checks++; if (fetch_count_retired !== 32'd1 || fetch_stall_cycles !== 32'd1) begin
            errors++; $display("FAIL perf_counters got=%0d/%0d exp=1/1", fetch_count_retired, fetch_stall_cycles);
        end
`endif
        $display("test_reset_midflight: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_branch_discard();
        test_branch_same_cycle();
        test_misaligned_stall();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front-end stage directly upstream of the load-use hazard check.
- Owns the program counter and issues one instruction-memory request at a time.
- Absorbs variable memory latency and drives the IF/ID register (instruction, PC, valid) into decode.
- Honours stall_pipeline from hazard detection; flushes and redirects on a taken branch resolved in execute.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value after reset
ADDRESS_WIDTH, 32, width of PC and memory address

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
stall_pipeline  input  1  hold IF/ID contents; from hazard detection
branch_taken_execute  input  1  redirect request from execute
branch_target_execute  input  ADDRESS_WIDTH  redirect target
instruction_request_valid  output  1  fetch request valid
instruction_request_address  output  ADDRESS_WIDTH  word-aligned fetch address
instruction_request_ready  input  1  memory accepts request
instruction_response_valid  input  1  fetched word valid (exactly one per accepted request)
instruction_response_data  input  32  fetched word
instruction_decode  output  32  IF/ID instruction
program_counter_decode  output  ADDRESS_WIDTH  IF/ID PC
valid_decode  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n low):
  - pc = RESET_VECTOR; state = FETCH_REQUEST.
  - valid_decode = 0; instruction_decode = 32'h0000_0013 (NOP); program_counter_decode = 0.
  - Skid buffer empty; discard flag clear; instruction_request_valid = 0 while in reset.
- Reset mid-operation drops all in-flight state. A response for a request issued before reset is never delivered (memory resets with the core).
- States:
  - FETCH_REQUEST:
    - Drive request_valid = 1, address = pc.
    - On ready: inflight_pc <= pc; pc <= pc+4 (wraps modulo 2^ADDRESS_WIDTH); go to WAIT_RESPONSE.
  - WAIT_RESPONSE:
    - request_valid = 0.
    - On response_valid with discard set: drop the word, clear discard, go to FETCH_REQUEST.
    - Otherwise, if IF/ID can accept (stall_pipeline=0 or valid_decode=0): load {data, inflight_pc, valid=1}, go to FETCH_REQUEST.
    - Otherwise: write the word into the skid buffer, go to HOLD.
  - HOLD:
    - request_valid = 0.
    - When stall_pipeline=0: skid contents move to IF/ID, go to FETCH_REQUEST.
- IF/ID update:
  - stall_pipeline=1 and no redirect: IF/ID unchanged.
  - stall_pipeline=0 and no new word this cycle: valid_decode <= 0 and instruction_decode <= NOP (bubble).
- Latency: request accepted in cycle N, response in cycle N+k → valid_decode=1 in cycle N+k+1. Peak throughput is one instruction per 2 cycles plus memory latency.
- Redirect (branch_taken_execute=1) overrides stall and all other updates:
  - pc <= {target[ADDRESS_WIDTH-1:2], 2'b00}.
  - valid_decode <= 0; IF/ID <= NOP; skid cleared.
  - Outstanding request at cycle end (WAIT_RESPONSE with no response this cycle, or a request accepted this cycle): set discard, stay in or enter WAIT_RESPONSE.
  - Response arriving in the same cycle: drop it, no discard, go to FETCH_REQUEST.
  - In HOLD or idle FETCH_REQUEST: go to FETCH_REQUEST.
- The request address always comes from the pc register. Target misalignment is silently cleared; no exception is raised here.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs fetch_count_retired[31:0] (+1 per word loaded into IF/ID, excluding discarded and bubble words) and fetch_stall_cycles[31:0] (+1 per cycle in WAIT_RESPONSE or HOLD).
  - Both reset to 0, wrap at 2^32, unaffected by redirect.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package riscv_core_pkg holds:
  - NOP encoding 32'h0000_0013.
  - Fetch state enum {FETCH_REQUEST, WAIT_RESPONSE, HOLD}.
  - Default RESET_VECTOR.
- One sub-module, fetch_skid_buffer: single-entry {data, pc, full} with load/drain/clear inputs. The PC logic and FSM stay in the top.

Test Plan:
- Reset release, zero-wait memory (ready=1, response next cycle) → addresses 0x0, 0x4, 0x8; valid_decode pulses with PC 0x0, 0x4, 0x8 in the cycles after each response.
- Response for PC 0x10 arrives while stall_pipeline=1 and valid_decode=1 → word captured in skid; IF/ID still shows 0xC; after stall drops, IF/ID = 0x10 next cycle; no new request until then.
- Branch to 0x200 while waiting on the response for 0x20 → the 0x20 word is discarded and never valid; next request address 0x200.
- Branch and response in the same cycle → response dropped, next-cycle request to the target, discard flag stays 0.
- Branch target 0x103 with stall_pipeline=1 → request 0x100; valid_decode=0 despite the stall.
- rst_n asserted during WAIT_RESPONSE → outputs immediately return to reset values; after release, the first request is RESET_VECTOR.
